am_mod_ramp_sequencer: RTL
==========================

Name: am_mod_ramp_sequencer

Overview:
- Control-plane sequencer that drives the center_fre and modulate_deep inputs of the AM modulator.
- Accepts one ramp command at a time over a valid/ready handshake. It then steps the carrier phase increment and the modulation depth from their current values toward command targets, in fixed increments, with a programmable dwell between updates.
- Sits between the register/host interface and the modulator. It gives glitch-free, rate-limited frequency and depth sweeps without any division hardware.

Parameters:
- PHASE_WIDTH, 32, width of center_fre and its target/increment.
- DEEP_WIDTH, 16, width of modulate_deep and its target/increment.
- DWELL_WIDTH, 16, width of the dwell counter.
- CNT_WIDTH, 12, width of the update counter.

Ports:
- clk, input, 1, system clock.
- RST, input, 1, asynchronous active-high reset.
- cfg_valid, input, 1, command valid.
- cfg_ready, output, 1, command accept; equals (state==IDLE).
- cfg_fre, input, PHASE_WIDTH, target center_fre.
- cfg_fre_inc, input, PHASE_WIDTH, center_fre step magnitude.
- cfg_deep, input, DEEP_WIDTH, target modulate_deep.
- cfg_deep_inc, input, DEEP_WIDTH, modulate_deep step magnitude.
- cfg_dwell, input, DWELL_WIDTH, idle cycles between updates.
- abort, input, 1, stop the ramp and hold the current values.
- center_fre, output, PHASE_WIDTH, registered, to the modulator.
- modulate_deep, output, DEEP_WIDTH, registered, to the modulator.
- busy, output, 1, high in RAMP.
- done, output, 1, one-cycle pulse when a ramp completes.
- aborted, output, 1, one-cycle pulse when a ramp is aborted.
- update_cnt, output, CNT_WIDTH, number of updates applied in the current or last ramp.

Behaviour:
- Clock and reset: one clock (clk); reset RST is asynchronous and active-high.
- Reset values: center_fre=0, modulate_deep=0, busy=0, done=0, aborted=0, update_cnt=0, state=IDLE. Hence cfg_ready=1.
- States: IDLE, RAMP, DONE.
- IDLE:
  - On cfg_valid & cfg_ready at a clk edge: latch all cfg_* fields, set dwell_cnt=cfg_dwell, clear update_cnt, go to RAMP.
  - busy is registered and goes high the cycle after accept.
  - abort is ignored in IDLE.
- RAMP, dwell counting:
  - dwell_cnt>0: decrement by one.
  - dwell_cnt==0: perform an update and reload dwell_cnt=dwell.
  - Updates therefore occur every dwell+1 cycles; the first one is dwell+1 edges after the accept edge.
- Update rule, applied independently per channel (fre and deep):
  - Compute the distance to target as an unsigned compare, no modular wrap.
  - If |target-current| <= inc, or inc==0: current <= target (snap).
  - Otherwise current <= current+inc when target>current, or current-inc when target<current.
  - Overshoot and wrap-around are impossible by construction.
  - update_cnt increments on every update and saturates at all-ones.
  - If both channels equal target after the update: go to DONE.
- DONE:
  - done=1 for exactly this one cycle; outputs already show the final values.
  - Next edge returns to IDLE and busy=0.
  - A command presented during DONE is not accepted until IDLE.
- Abort:
  - abort=1 in RAMP means the next edge goes to IDLE.
  - Outputs hold their current values, and any update scheduled on that edge is suppressed; abort has priority.
  - aborted pulses for one cycle; done is not asserted.
- Commands equal to the current values: one no-op update, then DONE. update_cnt=1.
- Outputs only change on update edges, so each channel is monotonic within a ramp.
- RST mid-ramp: everything returns to reset values immediately. Downstream sees center_fre=0 and modulate_deep=0.
- cfg_* inputs are don't-care except at the accept edge.

Test Plan:
- Reset, then command fre=100, fre_inc=40, deep=target 0, dwell=3. Required: center_fre 40/80/100 at edges 4/8/12 after accept, done high the cycle after edge 12, update_cnt=3, cfg_ready=1 after DONE.
- From fre=100 and deep=0, command fre=10, inc=30, deep=1000, deep_inc=300, dwell=0. Required: fre 70,40,10,10 and deep 300,600,900,1000 on consecutive edges, done after the 4th update, no overshoot.
- Command with fre_inc=0 and deep_inc=0, targets 0x12345678 and 0xFFFF. Required: both snap on the first update, update_cnt=1.
- Abort asserted on the same edge as the 2nd update of a ramp 0->100, inc 40. Required: center_fre holds 40, aborted pulses, done stays 0, state returns to IDLE.
- Hold cfg_valid high through RAMP and DONE. Required: cfg_ready=0 throughout and exactly one command accepted per completed ramp.
- Assert RST asynchronously mid-dwell, between edges. Required: outputs go to 0 and cfg_ready goes to 1 before the next clk edge.

Source files
------------

// File: rtl/am_mod_ramp_sequencer.sv
// Rate-limited ramp sequencer for the AM modulator's center_fre and modulate_deep inputs.
// One command at a time; each channel steps toward its target once every dwell+1 cycles.
module am_mod_ramp_sequencer #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned DEEP_WIDTH  = 16,
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_fre,
    input  logic [PHASE_WIDTH-1:0] cfg_fre_inc,
    input  logic [DEEP_WIDTH-1:0]  cfg_deep,
    input  logic [DEEP_WIDTH-1:0]  cfg_deep_inc,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] center_fre,
    output logic [DEEP_WIDTH-1:0]  modulate_deep,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [CNT_WIDTH-1:0]   update_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PHASE_WIDTH-1:0] r_fre_tgt;
    logic [PHASE_WIDTH-1:0] r_fre_inc;
    logic [DEEP_WIDTH-1:0]  r_deep_tgt;
    logic [DEEP_WIDTH-1:0]  r_deep_inc;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;

    logic [PHASE_WIDTH-1:0] w_fre_diff;
    logic [PHASE_WIDTH-1:0] w_fre_next;
    logic [DEEP_WIDTH-1:0]  w_deep_diff;
    logic [DEEP_WIDTH-1:0]  w_deep_next;
    logic                   w_at_target;

    assign cfg_ready = (r_state == IDLE);

    // Snap when within one step (or step is zero); distance is unsigned so no wrap.
    always_comb begin
        w_fre_next = r_fre_tgt;
        w_fre_diff = '0;
        if (r_fre_tgt > center_fre) begin
            w_fre_diff = r_fre_tgt - center_fre;
            if ((r_fre_inc != '0) && (w_fre_diff > r_fre_inc))
                w_fre_next = center_fre + r_fre_inc;
        end else begin
            w_fre_diff = center_fre - r_fre_tgt;
            if ((r_fre_inc != '0) && (w_fre_diff > r_fre_inc))
                w_fre_next = center_fre - r_fre_inc;
        end
    end

    always_comb begin
        w_deep_next = r_deep_tgt;
        w_deep_diff = '0;
        if (r_deep_tgt > modulate_deep) begin
            w_deep_diff = r_deep_tgt - modulate_deep;
            if ((r_deep_inc != '0) && (w_deep_diff > r_deep_inc))
                w_deep_next = modulate_deep + r_deep_inc;
        end else begin
            w_deep_diff = modulate_deep - r_deep_tgt;
            if ((r_deep_inc != '0) && (w_deep_diff > r_deep_inc))
                w_deep_next = modulate_deep - r_deep_inc;
        end
    end

    assign w_at_target = (w_fre_next == r_fre_tgt) && (w_deep_next == r_deep_tgt);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_fre_tgt     <= '0;
            r_fre_inc     <= '0;
            r_deep_tgt    <= '0;
            r_deep_inc    <= '0;
            r_dwell       <= '0;
            r_dwell_cnt   <= '0;
            center_fre    <= '0;
            modulate_deep <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            update_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_fre_tgt   <= cfg_fre;
                        r_fre_inc   <= cfg_fre_inc;
                        r_deep_tgt  <= cfg_deep;
                        r_deep_inc  <= cfg_deep_inc;
                        r_dwell     <= cfg_dwell;
                        r_dwell_cnt <= cfg_dwell;
                        update_cnt  <= '0;
                        busy        <= 1'b1;
                        r_state     <= RAMP;
                    end
                end
                RAMP: begin
                    // Abort wins over any update due on the same edge.
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_WIDTH'(1);
                    end else begin
                        center_fre    <= w_fre_next;
                        modulate_deep <= w_deep_next;
                        r_dwell_cnt   <= r_dwell;
                        if (update_cnt != '1)
                            update_cnt <= update_cnt + CNT_WIDTH'(1);
                        if (w_at_target) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
